tron_input_conditioner: RTL and testbench

//  Generalised front end for the game controllers wired to GPIO: N players x B buttons.

---
 rtl/tron_input_conditioner.sv | 120 ++++++++++++
 tb/tb_tron_input_conditioner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tron_input_conditioner.sv
// Sync/debounce/edge-detect per pin; raw edge to btn_level is 2+DEBOUNCE_CYCLES cycles, press pulse coincident.
// Per-player pending turn applied on tick (turn_applied next cycle); no backpressure, all outputs registered.
module tron_input_conditioner #(
    parameter int                         NUM_PLAYERS     = 2,
    parameter int                         BTN_W           = 3,
    parameter int                         LEFT_IDX        = 0,
    parameter int                         RIGHT_IDX       = 1,
    parameter int                         ACTIVE_LOW      = 1,
    parameter int                         DEBOUNCE_CYCLES = 500000,
    parameter logic [2*NUM_PLAYERS-1:0]   INIT_HEADINGS   = 4'b11_01
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_PLAYERS*BTN_W-1:0]   btn_raw,
    input  logic                           tick,
    output logic [NUM_PLAYERS*BTN_W-1:0]   btn_level,
    output logic [NUM_PLAYERS*BTN_W-1:0]   btn_press,
    output logic [2*NUM_PLAYERS-1:0]       heading,
    output logic [NUM_PLAYERS-1:0]         turn_applied
);

    localparam int NB = NUM_PLAYERS * BTN_W;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        PEND_NONE  = 2'd0,
        PEND_LEFT  = 2'd1,
        PEND_RIGHT = 2'd2
    } pend_e;

    logic [NB-1:0]              sync1_q, sync1_d;
    logic [NB-1:0]              sync2_q, sync2_d;
    logic [NB-1:0]              level_q, level_d;
    logic [NB-1:0]              press_q, press_d;
    logic [CW-1:0]              cnt_q [NB];
    logic [CW-1:0]              cnt_d [NB];
    pend_e                      pend_q [NUM_PLAYERS];
    pend_e                      pend_d [NUM_PLAYERS];
    logic [2*NUM_PLAYERS-1:0]   heading_q, heading_d;
    logic [NUM_PLAYERS-1:0]     applied_q, applied_d;

    always_comb begin
        sync1_d = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    // Tick consumes the pending turn first; a request in the same cycle then
    // becomes the new pending turn, so it waits for the following tick.
    always_comb begin
        heading_d = heading_q;
        applied_d = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            pend_d[p] = pend_q[p];
            if (tick && (pend_q[p] != PEND_NONE)) begin
                if (pend_q[p] == PEND_LEFT) begin
                    heading_d[2*p +: 2] = heading_q[2*p +: 2] - 2'd1;
                end else begin
                    heading_d[2*p +: 2] = heading_q[2*p +: 2] + 2'd1;
                end
                applied_d[p] = 1'b1;
                pend_d[p]    = PEND_NONE;
            end
            if (press_q[p*BTN_W + LEFT_IDX] && !press_q[p*BTN_W + RIGHT_IDX]) begin
                pend_d[p] = PEND_LEFT;
            end else if (press_q[p*BTN_W + RIGHT_IDX] && !press_q[p*BTN_W + LEFT_IDX]) begin
                pend_d[p] = PEND_RIGHT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            heading_q <= INIT_HEADINGS;
            applied_q <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                pend_q[p] <= PEND_NONE;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            heading_q <= heading_d;
            applied_q <= applied_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                pend_q[p] <= pend_d[p];
            end
        end
    end

    assign btn_level    = level_q;
    assign btn_press    = press_q;
    assign heading      = heading_q;
    assign turn_applied = applied_q;

endmodule

// File: tb/tb_tron_input_conditioner.sv
// Directed bench for tron_input_conditioner with DEBOUNCE_CYCLES=4, active-low pins.
module tb_tron_input_conditioner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] btn_raw;
    logic       tick;
    logic [5:0] btn_level;
    logic [5:0] btn_press;
    logic [3:0] heading;
    logic [1:0] turn_applied;

    int vectors    = 0;
    int miscompares = 0;

    tron_input_conditioner #(
        .NUM_PLAYERS    (2),
        .BTN_W          (3),
        .LEFT_IDX       (0),
        .RIGHT_IDX      (1),
        .ACTIVE_LOW     (1),
        .DEBOUNCE_CYCLES(4),
        .INIT_HEADINGS  (4'b11_01)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_raw     (btn_raw),
        .tick        (tick),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .heading     (heading),
        .turn_applied(turn_applied)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full press and release of one pin; leaves the pin released and debounced.
    task automatic press_btn(input int idx);
        btn_raw[idx] = 1'b0;
        step(6);
        btn_raw[idx] = 1'b1;
        step(6);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        btn_raw = 6'b111111;
        tick    = 1'b0;

        // 1: reset with pins toggling
        for (int i = 0; i < 5; i++) begin
            btn_raw = 6'($urandom);
            step(1);
        end
        chk("rst_level",   btn_level,    6'b000000);
        chk("rst_press",   btn_press,    6'b000000);
        chk("rst_heading", heading,      4'b1101);
        chk("rst_applied", turn_applied, 2'b00);
        btn_raw = 6'b111111;
        step(3);
        reset_n = 1'b1;
        step(2);
        chk("idle_level", btn_level, 6'b000000);

        // 2: debounce latency, P0 LEFT held
        btn_raw[0] = 1'b0;
        step(5);
        chk("deb_lvl_5",   btn_level, 6'b000000);
        chk("deb_press_5", btn_press, 6'b000000);
        step(1);
        chk("deb_lvl_6",   btn_level, 6'b000001);
        chk("deb_press_6", btn_press, 6'b000001);
        step(1);
        chk("deb_press_7", btn_press, 6'b000000);
        step(3);
        chk("deb_hold_lvl",   btn_level, 6'b000001);
        chk("deb_hold_press", btn_press, 6'b000000);
        btn_raw[0] = 1'b1;
        step(5);
        chk("rel_lvl_5", btn_level, 6'b000001);
        step(1);
        chk("rel_lvl_6",   btn_level, 6'b000000);
        chk("rel_press_6", btn_press, 6'b000000);

        // pending LEFT from the press above: E -> N
        pulse_tick();
        chk("p0_to_n_hdg", heading,      4'b1100);
        chk("p0_to_n_app", turn_applied, 2'b01);
        step(1);
        chk("p0_app_clr", turn_applied, 2'b00);

        // 2b: 3-cycle glitch on P0 button 2 is rejected
        btn_raw[2] = 1'b0;
        step(3);
        btn_raw[2] = 1'b1;
        step(8);
        chk("glitch_lvl",   btn_level, 6'b000000);
        chk("glitch_press", btn_press, 6'b000000);

        // 3: wrap N -LEFT-> W, then W -RIGHT-> N
        press_btn(0);
        chk("no_tick_hdg", heading, 4'b1100);
        pulse_tick();
        chk("wrap_l_hdg", heading,      4'b1111);
        chk("wrap_l_app", turn_applied, 2'b01);
        step(1);
        chk("wrap_l_app_clr", turn_applied, 2'b00);
        press_btn(1);
        pulse_tick();
        chk("wrap_r_hdg", heading,      4'b1100);
        chk("wrap_r_app", turn_applied, 2'b01);
        step(1);
        pulse_tick();
        chk("empty_tick_hdg", heading,      4'b1100);
        chk("empty_tick_app", turn_applied, 2'b00);

        // 4: P1 LEFT then RIGHT -> latest wins, W + 1 -> N
        press_btn(3);
        press_btn(4);
        pulse_tick();
        chk("ovr_hdg", heading,      4'b0000);
        chk("ovr_app", turn_applied, 2'b10);
        step(1);
        // simultaneous L and R presses cancel
        btn_raw[3] = 1'b0;
        btn_raw[4] = 1'b0;
        step(6);
        chk("cancel_press", btn_press, 6'b011000);
        btn_raw[3] = 1'b1;
        btn_raw[4] = 1'b1;
        step(6);
        pulse_tick();
        chk("cancel_hdg", heading,      4'b0000);
        chk("cancel_app", turn_applied, 2'b00);

        // 5: request in the tick cycle itself waits for the next tick
        step(1);
        btn_raw[1] = 1'b0;
        step(6);
        chk("coll_press", btn_press, 6'b000010);
        pulse_tick();
        chk("coll_hdg", heading,      4'b0000);
        chk("coll_app", turn_applied, 2'b00);
        btn_raw[1] = 1'b1;
        step(6);
        pulse_tick();
        chk("coll_next_hdg", heading,      4'b0001);
        chk("coll_next_app", turn_applied, 2'b01);
        step(1);

        // 6: reset at cnt=2 restarts the full debounce
        btn_raw[2] = 1'b0;
        step(4);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        chk("mid_rst_lvl", btn_level, 6'b000000);
        chk("mid_rst_hdg", heading,   4'b1101);
        step(5);
        chk("mid_rst_lvl_5", btn_level, 6'b000000);
        step(1);
        chk("mid_rst_lvl_6",   btn_level, 6'b000100);
        chk("mid_rst_press_6", btn_press, 6'b000100);
        btn_raw[2] = 1'b1;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
